// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: arbitrates ALU and LSU writeback requests onto a single
// registered register-file write port and counts requester conflicts.
// Optional feature: define RF_WB_FWD_EN to add rs1/rs2 forwarding from the
// registered write port.
//
// Handshake: a request transfers when valid and ready are both high at a
// rising edge of i_clk. Ready is asserted only to the granted requester and
// only while its valid is high (ready depends combinationally on valid).
// Requesters hold valid and payload stable until accepted.
module rf_wb_arbiter #(
   parameter int LSU_FIXED_PRIO = 0,
   parameter int CNT_W          = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_alu_valid,
   input  logic [4:0]       i_alu_rd_addr,
   input  logic [31:0]      i_alu_rd_data,
   output logic             o_alu_ready,
   input  logic             i_lsu_valid,
   input  logic [4:0]       i_lsu_rd_addr,
   input  logic [31:0]      i_lsu_rd_data,
   output logic             o_lsu_ready,
   output logic             o_rd_wren,
   output logic [4:0]       o_rd_addr,
   output logic [31:0]      o_rd_data,
`ifdef RF_WB_FWD_EN
   input  logic [4:0]       i_rs1_addr,
   input  logic [4:0]       i_rs2_addr,
   output logic             o_fwd_rs1_hit,
   output logic [31:0]      o_fwd_rs1_data,
   output logic             o_fwd_rs2_hit,
   output logic [31:0]      o_fwd_rs2_data,
`endif
   output logic [CNT_W-1:0] o_conflict_cnt
);

   // 1 = the last completed transfer came from the LSU; reset to LSU so the
   // ALU wins the first tie.
   logic        last_grant_lsu;
   logic        grant_alu;
   logic        grant_lsu;
   logic        xfer;
   logic [4:0]  sel_addr;
   logic [31:0] sel_data;

   // Grant selection: single requester always wins; ties go by priority mode.
   always_comb begin
      grant_alu = 1'b0;
      grant_lsu = 1'b0;
      if (i_alu_valid && i_lsu_valid) begin
         if (LSU_FIXED_PRIO != 0) begin
            grant_lsu = 1'b1;
         end else if (last_grant_lsu) begin
            grant_alu = 1'b1;
         end else begin
            grant_lsu = 1'b1;
         end
      end else if (i_alu_valid) begin
         grant_alu = 1'b1;
      end else if (i_lsu_valid) begin
         grant_lsu = 1'b1;
      end
   end

   // Ready is held low throughout reset so nothing is accepted.
   always_comb begin
      o_alu_ready = grant_alu && !i_rst;
      o_lsu_ready = grant_lsu && !i_rst;
      xfer        = o_alu_ready || o_lsu_ready;
      sel_addr    = o_lsu_ready ? i_lsu_rd_addr : i_alu_rd_addr;
      sel_data    = o_lsu_ready ? i_lsu_rd_data : i_alu_rd_data;
   end

   // Registered write port; writes to x0 complete the handshake but never
   // raise the write enable. Address/data hold when nothing transfers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_rd_wren <= 1'b0;
         o_rd_addr <= 5'd0;
         o_rd_data <= 32'd0;
      end else begin
         o_rd_wren <= xfer && (sel_addr != 5'd0);
         if (xfer) begin
            o_rd_addr <= sel_addr;
            o_rd_data <= sel_data;
         end
      end
   end

   // Last-grant record moves only on a completed transfer.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         last_grant_lsu <= 1'b1;
      end else if (xfer) begin
         last_grant_lsu <= o_lsu_ready;
      end
   end

   // Saturating count of edges where both requesters were valid.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_conflict_cnt <= '0;
      end else if (i_alu_valid && i_lsu_valid &&
                   (o_conflict_cnt != {CNT_W{1'b1}})) begin
         o_conflict_cnt <= o_conflict_cnt + 1'b1;
      end
   end

`ifdef RF_WB_FWD_EN
   // Forward the write currently on the port to matching non-x0 sources.
   always_comb begin
      o_fwd_rs1_hit  = o_rd_wren && (i_rs1_addr == o_rd_addr) && (i_rs1_addr != 5'd0);
      o_fwd_rs2_hit  = o_rd_wren && (i_rs2_addr == o_rd_addr) && (i_rs2_addr != 5'd0);
      o_fwd_rs1_data = o_fwd_rs1_hit ? o_rd_data : 32'd0;
      o_fwd_rs2_data = o_fwd_rs2_hit ? o_rd_data : 32'd0;
   end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: one round-robin instance (default counter width)
// and one fixed-LSU-priority instance with a 3-bit counter for saturation.
module tb_rf_wb_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b0;

   // Clock/reset block
   always #5 clk = ~clk;

   // Round-robin instance signals
   logic        a_alu_valid, a_lsu_valid, a_alu_ready, a_lsu_ready;
   logic [4:0]  a_alu_addr, a_lsu_addr, a_addr;
   logic [31:0] a_alu_data, a_lsu_data, a_data;
   logic        a_wren;
   logic [15:0] a_cnt;
   // Fixed-priority instance signals
   logic        b_alu_valid, b_lsu_valid, b_alu_ready, b_lsu_ready;
   logic [4:0]  b_alu_addr, b_lsu_addr, b_addr;
   logic [31:0] b_alu_data, b_lsu_data, b_data;
   logic        b_wren;
   logic [2:0]  b_cnt;
`ifdef RF_WB_FWD_EN
   logic [4:0]  a_rs1, a_rs2, b_rs1, b_rs2;
   logic        a_hit1, a_hit2, b_hit1, b_hit2;
   logic [31:0] a_fd1, a_fd2, b_fd1, b_fd2;
`endif

   rf_wb_arbiter #(.LSU_FIXED_PRIO(0), .CNT_W(16)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_alu_valid(a_alu_valid), .i_alu_rd_addr(a_alu_addr), .i_alu_rd_data(a_alu_data),
      .o_alu_ready(a_alu_ready),
      .i_lsu_valid(a_lsu_valid), .i_lsu_rd_addr(a_lsu_addr), .i_lsu_rd_data(a_lsu_data),
      .o_lsu_ready(a_lsu_ready),
      .o_rd_wren(a_wren), .o_rd_addr(a_addr), .o_rd_data(a_data),
`ifdef RF_WB_FWD_EN
      .i_rs1_addr(a_rs1), .i_rs2_addr(a_rs2),
      .o_fwd_rs1_hit(a_hit1), .o_fwd_rs1_data(a_fd1),
      .o_fwd_rs2_hit(a_hit2), .o_fwd_rs2_data(a_fd2),
`endif
      .o_conflict_cnt(a_cnt)
   );

   rf_wb_arbiter #(.LSU_FIXED_PRIO(1), .CNT_W(3)) dut_fp (
      .i_clk(clk), .i_rst(rst),
      .i_alu_valid(b_alu_valid), .i_alu_rd_addr(b_alu_addr), .i_alu_rd_data(b_alu_data),
      .o_alu_ready(b_alu_ready),
      .i_lsu_valid(b_lsu_valid), .i_lsu_rd_addr(b_lsu_addr), .i_lsu_rd_data(b_lsu_data),
      .o_lsu_ready(b_lsu_ready),
      .o_rd_wren(b_wren), .o_rd_addr(b_addr), .o_rd_data(b_data),
`ifdef RF_WB_FWD_EN
      .i_rs1_addr(b_rs1), .i_rs2_addr(b_rs2),
      .o_fwd_rs1_hit(b_hit1), .o_fwd_rs1_data(b_fd1),
      .o_fwd_rs2_hit(b_hit2), .o_fwd_rs2_data(b_fd2),
`endif
      .o_conflict_cnt(b_cnt)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [36:0] exp_q0[$];
   logic [36:0] exp_q1[$];
   logic [36:0] e0, e1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Driver for the round-robin instance: one cycle of stimulus, ready check
   // against hand-computed grant, expected write pushed to the scoreboard.
   task automatic drive0(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld,
                         input logic exp_ar, input logic exp_lr, input string tag);
      a_alu_valid = av; a_alu_addr = aa; a_alu_data = ad;
      a_lsu_valid = lv; a_lsu_addr = la; a_lsu_data = ld;
      @(negedge clk);
      chk({tag, "_alu_ready"}, a_alu_ready, exp_ar);
      chk({tag, "_lsu_ready"}, a_lsu_ready, exp_lr);
      if (exp_ar && aa != 5'd0) exp_q0.push_back({aa, ad});
      if (exp_lr && la != 5'd0) exp_q0.push_back({la, ld});
      @(posedge clk);
      #1;
   endtask

   // Driver for the fixed-priority instance.
   task automatic drive1(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld,
                         input logic exp_ar, input logic exp_lr, input string tag);
      b_alu_valid = av; b_alu_addr = aa; b_alu_data = ad;
      b_lsu_valid = lv; b_lsu_addr = la; b_lsu_data = ld;
      @(negedge clk);
      chk({tag, "_alu_ready"}, b_alu_ready, exp_ar);
      chk({tag, "_lsu_ready"}, b_lsu_ready, exp_lr);
      if (exp_ar && aa != 5'd0) exp_q1.push_back({aa, ad});
      if (exp_lr && la != 5'd0) exp_q1.push_back({la, ld});
      @(posedge clk);
      #1;
   endtask

   task automatic idle0();
      drive0(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, "idle0");
   endtask

   task automatic pulse_reset();
      a_alu_valid = 1'b0; a_lsu_valid = 1'b0;
      b_alu_valid = 1'b0; b_lsu_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Scoreboard monitors: pop and compare on every presented write.
   always @(negedge clk) begin
      if (a_wren === 1'b1) begin
         if (exp_q0.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL rr_unexpected_write: got addr 0x%0h data 0x%0h, expected no write", a_addr, a_data);
         end else begin
            e0 = exp_q0.pop_front();
            chk("rr_wr_addr", a_addr, e0[36:32]);
            chk("rr_wr_data", a_data, e0[31:0]);
         end
      end
   end

   always @(negedge clk) begin
      if (b_wren === 1'b1) begin
         if (exp_q1.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL fp_unexpected_write: got addr 0x%0h data 0x%0h, expected no write", b_addr, b_data);
         end else begin
            e1 = exp_q1.pop_front();
            chk("fp_wr_addr", b_addr, e1[36:32]);
            chk("fp_wr_data", b_data, e1[31:0]);
         end
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   // Directed stimulus
   initial begin
      a_alu_valid = 1'b0; a_alu_addr = 5'd0; a_alu_data = 32'd0;
      a_lsu_valid = 1'b0; a_lsu_addr = 5'd0; a_lsu_data = 32'd0;
      b_alu_valid = 1'b0; b_alu_addr = 5'd0; b_alu_data = 32'd0;
      b_lsu_valid = 1'b0; b_lsu_addr = 5'd0; b_lsu_data = 32'd0;
`ifdef RF_WB_FWD_EN
      a_rs1 = 5'd0; a_rs2 = 5'd0; b_rs1 = 5'd0; b_rs2 = 5'd0;
`endif
      #1 rst = 1'b1;
      // Requests held during reset must not be accepted.
      a_alu_valid = 1'b1; a_alu_addr = 5'd1; a_alu_data = 32'h1;
      a_lsu_valid = 1'b1; a_lsu_addr = 5'd2; a_lsu_data = 32'h2;
      b_alu_valid = 1'b1; b_lsu_valid = 1'b1;
      b_alu_addr = 5'd1; b_lsu_addr = 5'd2;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_alu_ready", a_alu_ready, 1'b0);
      chk("rst_lsu_ready", a_lsu_ready, 1'b0);
      chk("rst_fp_lsu_ready", b_lsu_ready, 1'b0);
      chk("rst_wren", a_wren, 1'b0);
      chk("rst_addr", a_addr, 5'd0);
      chk("rst_data", a_data, 32'd0);
      chk("rst_cnt", a_cnt, 16'd0);
      a_alu_valid = 1'b0; a_lsu_valid = 1'b0;
      b_alu_valid = 1'b0; b_lsu_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;

      // First transfer after reset: ALU rd=5.
      drive0(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, "first");
      chk("first_wren", a_wren, 1'b1);
      chk("first_addr", a_addr, 5'd5);
      chk("first_data", a_data, 32'hDEADBEEF);
      idle0();
      chk("idle_wren", a_wren, 1'b0);
      chk("idle_hold_data", a_data, 32'hDEADBEEF);

      // Reset right after a transfer edge discards the registered write.
      a_alu_valid = 1'b1; a_alu_addr = 5'd9; a_alu_data = 32'h99;
      @(negedge clk);
      chk("midrst_alu_ready", a_alu_ready, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      a_alu_valid = 1'b0;
      #1;
      chk("midrst_wren", a_wren, 1'b0);
      chk("midrst_addr", a_addr, 5'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) idle0();

      // Same destination from both: ALU first, then LSU.
      drive0(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 1'b1, 1'b0, "same_rd_c0");
      drive0(1'b0, 5'd0, 32'd0,  1'b1, 5'd7, 32'h22, 1'b0, 1'b1, "same_rd_c1");
      idle0();
      chk("same_rd_final", a_data, 32'h22);
      chk("same_rd_cnt", a_cnt, 16'd1);

      // Round-robin over four tie cycles with fresh payloads.
      pulse_reset();
      for (int i = 0; i < 4; i++) begin
         drive0(1'b1, 5'(10 + i), 32'hA0 + i, 1'b1, 5'(20 + i), 32'hB0 + i,
                (i % 2) == 0, (i % 2) == 1, "rr");
      end
      idle0();
      chk("rr_cnt", a_cnt, 16'd4);

      // Lone requester wins regardless of the last-grant record.
      drive0(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h55, 1'b0, 1'b1, "lone_lsu");
      drive0(1'b1, 5'd13, 32'h66, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, "lone_alu");

      // Write to x0: accepted, no write enable, address/data still update.
      drive0(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, 1'b0, 1'b1, "x0");
      chk("x0_wren", a_wren, 1'b0);
      chk("x0_addr", a_addr, 5'd0);
      chk("x0_data", a_data, 32'h1234);
      idle0();
      chk("x0_hold_data", a_data, 32'h1234);

      // Registered write then forwarding lookup.
      drive0(1'b1, 5'd3, 32'hA5, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, "fwd_wr");
`ifdef RF_WB_FWD_EN
      a_rs1 = 5'd3; a_rs2 = 5'd0;
      #1;
      chk("fwd_rs1_hit", a_hit1, 1'b1);
      chk("fwd_rs1_data", a_fd1, 32'hA5);
      chk("fwd_rs2_hit", a_hit2, 1'b0);
      chk("fwd_rs2_data", a_fd2, 32'd0);
      idle0();
      chk("fwd_stale_hit", a_hit1, 1'b0);
      chk("fwd_stale_data", a_fd1, 32'd0);
`else
      idle0();
`endif

      // Fixed LSU priority: LSU takes every tie, ALU waits.
      for (int i = 0; i < 3; i++) begin
         drive1(1'b1, 5'd4, 32'hC0, 1'b1, 5'(8 + i), 32'hD0 + i, 1'b0, 1'b1, "fp");
      end
      chk("fp_cnt3", b_cnt, 3'd3);
      for (int i = 3; i < 9; i++) begin
         drive1(1'b1, 5'd4, 32'hC0, 1'b1, 5'(8 + i), 32'hD0 + i, 1'b0, 1'b1, "fp_sat");
      end
      chk("fp_cnt_sat", b_cnt, 3'd7);
      drive1(1'b1, 5'd4, 32'hC0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, "fp_alu");
      drive1(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, "fp_idle");
      chk("fp_alu_data", b_data, 32'hC0);
      chk("fp_cnt_hold", b_cnt, 3'd7);

      repeat (2) idle0();
      chk("rr_queue_drained", exp_q0.size(), 0);
      chk("fp_queue_drained", exp_q1.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
